// File: rtl/store_unit.sv
// Store unit: turns an execute-stage store into lane-aligned data memory beats.
// Define STORE_SPLIT_MISALIGNED_EN to split misaligned SH/SW into up to two beats.
module store_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t            r_state;
  logic              r_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic              r_done;
  logic              r_err;

  logic [1:0]        w_off;
  logic [ADDR_W-1:0] w_base;
  logic              w_legal;
  logic [3:0]        w_be0;
  logic [31:0]       w_wd0;

  assign w_off  = req_addr[1:0];
  assign w_base = {req_addr[ADDR_W-1:2], 2'b00};

`ifdef STORE_SPLIT_MISALIGNED_EN
  logic              r_two;
  logic [ADDR_W-1:0] r_b1_addr;
  logic [3:0]        r_b1_be;
  logic [31:0]       r_b1_wdata;
  logic              w_two;
  logic [3:0]        w_be1;
  logic [31:0]       w_wd1;
  logic [3:0]        w_mask;
  logic [7:0]        w_span;
  logic [63:0]       w_d64;

  // Upper nibble / upper word of the shifted mask and data spill into the next word.
  assign w_mask = (req_funct3 == 3'b001) ? 4'b0011 : 4'b1111;
  assign w_span = {4'b0000, w_mask} << w_off;
  assign w_d64  = {32'h0, req_data} << {w_off, 3'b000};
`endif

  always_comb begin
    w_legal = 1'b0;
    w_be0   = '0;
    w_wd0   = '0;
`ifdef STORE_SPLIT_MISALIGNED_EN
    w_two   = 1'b0;
    w_be1   = '0;
    w_wd1   = '0;
`endif
    case (req_funct3)
      3'b000: begin
        w_legal = 1'b1;
        w_be0   = 4'b0001 << w_off;
        w_wd0   = {4{req_data[7:0]}};
      end
      3'b001, 3'b010: begin
        if (req_funct3 == 3'b001 && !w_off[0]) begin
          w_legal = 1'b1;
          w_be0   = 4'b0011 << w_off;
          w_wd0   = {2{req_data[15:0]}};
        end else if (req_funct3 == 3'b010 && w_off == 2'b00) begin
          w_legal = 1'b1;
          w_be0   = 4'b1111;
          w_wd0   = req_data;
        end
`ifdef STORE_SPLIT_MISALIGNED_EN
        else begin
          w_legal = 1'b1;
          w_be0   = w_span[3:0];
          w_wd0   = w_d64[31:0];
          w_two   = |w_span[7:4];
          w_be1   = w_span[7:4];
          w_wd1   = w_d64[63:32];
        end
`endif
      end
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef STORE_SPLIT_MISALIGNED_EN
      r_two      <= 1'b0;
      r_b1_addr  <= '0;
      r_b1_be    <= '0;
      r_b1_wdata <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid && r_ready) begin
            r_ready <= 1'b0;
            if (w_legal) begin
              r_we    <= 1'b1;
              r_addr  <= w_base;
              r_be    <= w_be0;
              r_wdata <= w_wd0;
              r_state <= BEAT0;
`ifdef STORE_SPLIT_MISALIGNED_EN
              r_two      <= w_two;
              r_b1_addr  <= w_base + ADDR_W'(4);
              r_b1_be    <= w_be1;
              r_b1_wdata <= w_wd1;
`endif
            end else begin
              r_err   <= 1'b1;
              r_state <= RESP;
            end
          end
        end
        BEAT0: begin
          if (dmem_ack) begin
`ifdef STORE_SPLIT_MISALIGNED_EN
            if (r_two) begin
              r_addr  <= r_b1_addr;
              r_be    <= r_b1_be;
              r_wdata <= r_b1_wdata;
              r_state <= BEAT1;
            end else begin
              r_we    <= 1'b0;
              r_done  <= 1'b1;
              r_state <= RESP;
            end
`else
            r_we    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= RESP;
`endif
          end
        end
        BEAT1: begin
          if (dmem_ack) begin
            r_we    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= RESP;
          end
        end
        RESP: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_we    <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign dmem_be    = r_be;
  assign done       = r_done;
  assign err        = r_err;

endmodule
